// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse symbol sequencer.
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2,
      ST_TAIL  = 2'd3
   } state_e;

   localparam int unsigned DOT_UNITS        = 1;
   localparam int unsigned DASH_UNITS       = 3;
   localparam int unsigned SYM_GAP_UNITS    = 1;
   localparam int unsigned LETTER_GAP_UNITS = 3;
   localparam int          MAX_SYM_DEFAULT  = 5;

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Control/status bundle between the code ROM side and the Morse sequencer.
interface morse_symbol_sequencer_if
   import morse_pkg::*;
#(
   parameter int MAX_SYM = morse_pkg::MAX_SYM_DEFAULT
) ();

   // Handshake: start is a one-shot request honoured only while busy is low;
   // code_bits/code_len are captured on that cycle. busy is the only ready indication.
   logic               start;
   logic               abort;
   logic [MAX_SYM-1:0] code_bits;
   logic [2:0]         code_len;
   logic               led;
   logic               busy;
   logic               done;
   state_e             state;

   modport master (
      output start, abort, code_bits, code_len,
      input  led, busy, done, state
   );

   modport slave (
      input  start, abort, code_bits, code_len,
      output led, busy, done, state
   );

endinterface

// File: rtl/morse_unit_timer.sv
// Divides the shared 1 ms tick into Morse unit pulses.
module morse_unit_timer #(
   parameter int UNIT_MS = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick_1ms,
   output logic unit_pulse
);

   localparam int              MS_W    = (UNIT_MS > 1) ? $clog2(UNIT_MS) : 1;
   localparam logic [MS_W-1:0] MS_LAST = MS_W'(UNIT_MS - 1);

   logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;

   assign unit_pulse = tick_1ms && (ms_cnt_q == MS_LAST);

   always_comb begin
      ms_cnt_d = ms_cnt_q;
      if (clear)
         ms_cnt_d = '0;
      else if (tick_1ms)
         ms_cnt_d = unit_pulse ? '0 : ms_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ms_cnt_q <= '0;
      else     ms_cnt_q <= ms_cnt_d;
   end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Plays one latched Morse character on a single output, timing marks and gaps in units.
module morse_symbol_sequencer
   import morse_pkg::*;
#(
   parameter int UNIT_MS = 100,
   parameter int MAX_SYM = MAX_SYM_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick_1ms,
   morse_symbol_sequencer_if.slave  bus
);

   localparam logic [2:0] MAX_LEN = 3'(MAX_SYM);

   state_e             state_q, state_d;
   logic [MAX_SYM-1:0] bits_q, bits_d;
   logic [2:0]         len_q, len_d;
   logic [2:0]         sym_idx_q, sym_idx_d;
   logic [1:0]         unit_cnt_q, unit_cnt_d;
   logic               led_q, busy_q, done_q;
   logic               done_d;
   logic               is_dash;
   logic [1:0]         last_unit;
   logic               expire;
   logic               unit_pulse;
   logic               timer_clear;

   morse_unit_timer #(.UNIT_MS(UNIT_MS)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (timer_clear),
      .tick_1ms   (tick_1ms),
      .unit_pulse (unit_pulse)
   );

   // Expiry = the unit pulse that completes the current state's unit target.
   always_comb begin
      is_dash = |(bits_q & (MAX_SYM'(1) << sym_idx_q));
      case (state_q)
         ST_MARK:  last_unit = is_dash ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
         ST_SPACE: last_unit = 2'(SYM_GAP_UNITS - 1);
         ST_TAIL:  last_unit = 2'(LETTER_GAP_UNITS - 1);
         default:  last_unit = '0;
      endcase
      expire = unit_pulse && (unit_cnt_q == last_unit) && (state_q != ST_IDLE);
   end

   always_comb begin
      state_d   = state_q;
      bits_d    = bits_q;
      len_d     = len_q;
      sym_idx_d = sym_idx_q;
      case (state_q)
         ST_IDLE: begin
            sym_idx_d = '0;
            if (bus.start) begin
               bits_d  = bus.code_bits;
               len_d   = (bus.code_len > MAX_LEN) ? MAX_LEN : bus.code_len;
               state_d = (bus.code_len == 3'd0) ? ST_TAIL : ST_MARK;
            end
         end
         ST_MARK:  if (expire) state_d = ((sym_idx_q + 3'd1) < len_q) ? ST_SPACE : ST_TAIL;
         ST_SPACE: if (expire) begin
            sym_idx_d = sym_idx_q + 3'd1;
            state_d   = ST_MARK;
         end
         ST_TAIL:  if (expire) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (bus.abort && (state_q != ST_IDLE))
         state_d = ST_IDLE;

      // Counters restart on every transition and stay parked while idle.
      timer_clear = (state_d != state_q) || (state_q == ST_IDLE);
      if (timer_clear)     unit_cnt_d = '0;
      else if (unit_pulse) unit_cnt_d = unit_cnt_q + 2'd1;
      else                 unit_cnt_d = unit_cnt_q;

      done_d = expire && (state_q == ST_TAIL) && !bus.abort;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bits_q     <= '0;
         len_q      <= '0;
         sym_idx_q  <= '0;
         unit_cnt_q <= '0;
         led_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bits_q     <= bits_d;
         len_q      <= len_d;
         sym_idx_q  <= sym_idx_d;
         unit_cnt_q <= unit_cnt_d;
         led_q      <= (state_d == ST_MARK);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= done_d;
      end
   end

   assign bus.led   = led_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.state = state_q;

endmodule

// File: doc/morse_symbol_sequencer.md
# morse_symbol_sequencer

- Plays one Morse character on a single lamp/buzzer output.
- Takes a latched dot/dash pattern and a symbol count, and times each mark and space by counting the shared 1 ms tick pulse.
- Sits between the code ROM lookup and the output LED. It is the timing controller that the game's millisecond and unit counters feed.

## Interface

Parameters:
- UNIT_MS, default 100: number of 1 ms ticks in one Morse unit. Simulation uses 3.
- MAX_SYM, default 5: maximum number of symbols per character.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- tick_1ms, input, 1: one-cycle pulse every millisecond.
- start, input, 1: request to play a character. Sampled only in IDLE.
- abort, input, 1: terminate playback immediately.
- code_bits, input, MAX_SYM: symbol pattern. Bit 0 is the first symbol; 1 = dash, 0 = dot.
- code_len, input, 3: number of symbols, 0..MAX_SYM.
- led, output, 1: Morse output, high during marks.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when a character completes normally.

## Operation

States are IDLE, MARK, SPACE, TAIL.

- **IDLE**
  - On start=1, latch code_bits and code_len. Values of code_len above MAX_SYM are clamped to MAX_SYM.
  - Clear sym_idx, ms_cnt and unit_cnt.
  - Go to MARK, or go to TAIL if code_len=0.
- **MARK**
  - led=1.
  - Target is 1 unit for a dot, 3 units for a dash.
  - On expiry: go to SPACE if sym_idx < len-1, otherwise go to TAIL.
- **SPACE**
  - led=0. Target is 1 unit.
  - On expiry: increment sym_idx and go to MARK.
- **TAIL**
  - led=0. Target is 3 units (inter-letter gap).
  - On expiry: go to IDLE and pulse done.

Counting:
- ms_cnt counts tick_1ms pulses from 0 to UNIT_MS-1. When it reaches UNIT_MS-1 on a tick, it wraps to 0 and a unit pulse is generated.
- unit_cnt counts unit pulses.
- Expiry is a unit pulse with unit_cnt = target-1.
- Both counters clear on every state change.
- ms_cnt is $clog2(UNIT_MS) bits wide. unit_cnt is 2 bits wide.

Abort:
- abort=1 in any non-IDLE state forces IDLE on the next edge.
- led drops, counters clear, and no done pulse is produced.
- abort in IDLE has no effect.
- abort has priority over start and over expiry.

start handling:
- start while busy is ignored. It is not queued.

## Timing

Reset values:
- led=0, busy=0, done=0, state=IDLE.
- All counters and latched registers are 0.

Outputs:
- All outputs are registered.
- led = (state==MARK). busy = (state!=IDLE).

Cycle-level behaviour:
- start at cycle t: MARK and led=1 at t+1. Ticks are counted from cycle t+1 onward. A tick coincident with the accepted start is not counted.
- Expiring tick at cycle t: the new state, and the matching led value, appear at t+1.
- done is high for exactly one cycle, the cycle in which state returns to IDLE. busy is 0 in that same cycle.
- A new start is accepted in the done cycle, with MARK at the following cycle.
- Mark duration is exactly (units × UNIT_MS) tick pulses, independent of the tick spacing in clocks.
- Back-to-back tick_1ms pulses on consecutive cycles are legal and each one counts.
- Reset asserted mid-character returns to IDLE asynchronously: led=0 immediately and no done pulse.

## Structure

- Package morse_pkg holds:
  - the state enum (IDLE, MARK, SPACE, TAIL);
  - the unit-multiple constants DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, LETTER_GAP_UNITS=3;
  - MAX_SYM_DEFAULT.
- Sub-module morse_unit_timer (clk, rst, clear, tick_1ms → unit_pulse) holds ms_cnt, parameterised by UNIT_MS.
- The FSM, unit_cnt, sym_idx and the pattern latch remain in the top module.

## Test plan

All scenarios use UNIT_MS=3 and a tick every 4 clocks.

- **Letter A** (code_bits=00010, len=2), start: led high 3 ticks, low 3, high 9, low 9. done pulses once. busy spans exactly 24 ticks plus 1 cycle.
- **Letter E** (bits=00000, len=1): led high 3 ticks, low 9, then done. No SPACE state is visited.
- **code_len=0**: busy for 9 ticks, led never high, then done. **code_len=7** behaves as len=5.
- **start ignored while busy**: start asserted at tick 5 during A → waveform identical to the A scenario. start in the done cycle → the next character begins at the following cycle.
- **abort in MARK** of the second symbol: led=0 and busy=0 on the next cycle, no done. abort and start together in IDLE → start is accepted.
- **Asynchronous reset**: rst pulsed mid-dash, between clock edges → led=0 before the next edge. After release, the state is IDLE and counters are 0.
